sec_tick_time_keeper: RTL and testbench

Consumer for the 1 Hz, 50/50 square-wave second tick produced by the half-second pulse generator. Synchronizes the tick, detects its rising edge, and maintains a 24-hour BCD time-of-day (hh:mm:ss) with a load handshake for setting the time. Sits between the tick generator and the display/UART formatting logic of the lab clock design.

---
 rtl/time_keeper_pkg.sv | 47 ++++
 rtl/bcd_pair_counter.sv | 57 +++++
 rtl/sec_tick_time_keeper.sv | 167 ++++++++++++++++
 tb/tb_sec_tick_time_keeper.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_keeper_pkg.sv
// Shared definitions for the second-tick time keeper: BCD digit layout,
// digit limits, load FSM states and the loaded-time validity check.
package time_keeper_pkg;

  localparam int DIGIT_W   = 4;
  localparam int TIME_W    = 6 * DIGIT_W;

  // Digit offsets inside the packed {h10,h1,m10,m1,s10,s1} word
  localparam int S1_OFF    = 0;
  localparam int S10_OFF   = 4;
  localparam int M1_OFF    = 8;
  localparam int M10_OFF   = 12;
  localparam int H1_OFF    = 16;
  localparam int H10_OFF   = 20;

  // Digit limits
  localparam int DIGIT_MAX = 9;
  localparam int TENS_MAX  = 5;
  localparam int HOUR_MAX  = 23;

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_e;

  // A time word is accepted only if every digit is decimal, the tens of
  // minutes/seconds are <= 5 and the hour pair does not exceed 23.
  function automatic logic is_valid_time(input logic [TIME_W-1:0] t);
    logic [DIGIT_W-1:0] s1, s10, m1, m10, h1, h10;
    logic               digits_ok, tens_ok, hour_ok;
    s1  = t[S1_OFF  +: DIGIT_W];
    s10 = t[S10_OFF +: DIGIT_W];
    m1  = t[M1_OFF  +: DIGIT_W];
    m10 = t[M10_OFF +: DIGIT_W];
    h1  = t[H1_OFF  +: DIGIT_W];
    h10 = t[H10_OFF +: DIGIT_W];
    digits_ok = (s1  <= 4'(DIGIT_MAX)) && (s10 <= 4'(DIGIT_MAX)) &&
                (m1  <= 4'(DIGIT_MAX)) && (m10 <= 4'(DIGIT_MAX)) &&
                (h1  <= 4'(DIGIT_MAX)) && (h10 <= 4'(DIGIT_MAX));
    tens_ok   = (s10 <= 4'(TENS_MAX)) && (m10 <= 4'(TENS_MAX));
    // With decimal digits, BCD ordering matches numeric ordering.
    hour_ok   = (h10 <  4'(HOUR_MAX / 10)) ||
                ((h10 == 4'(HOUR_MAX / 10)) && (h1 <= 4'(HOUR_MAX % 10)));
    return digits_ok && tens_ok && hour_ok;
  endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter with load and wrap at MODULUS (60 for seconds and
// minutes, 24 for hours). carry_out_o flags the increment that wraps to 00.
module bcd_pair_counter
  import time_keeper_pkg::*;
#(
  parameter int MODULUS = 60
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_i,
  input  logic       load_i,
  input  logic [7:0] load_value_i,
  output logic [7:0] value_o,
  output logic       carry_out_o
);

  localparam logic [DIGIT_W-1:0] LAST_HI = DIGIT_W'((MODULUS - 1) / 10);
  localparam logic [DIGIT_W-1:0] LAST_LO = DIGIT_W'((MODULUS - 1) % 10);

  logic [DIGIT_W-1:0] hi_q, lo_q, hi_d, lo_d;
  logic               at_last;

  assign at_last     = (hi_q == LAST_HI) && (lo_q == LAST_LO);
  assign carry_out_o = inc_i & ~load_i & at_last;
  assign value_o     = {hi_q, lo_q};

  // Next digit pair: load wins, otherwise per-digit BCD increment with wrap
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (load_i) begin
      {hi_d, lo_d} = load_value_i;
    end else if (inc_i) begin
      if (at_last) begin
        hi_d = '0;
        lo_d = '0;
      end else if (lo_q == DIGIT_W'(DIGIT_MAX)) begin
        hi_d = hi_q + 1'b1;
        lo_d = '0;
      end else begin
        lo_d = lo_q + 1'b1;
      end
    end
  end

  // Digit pair register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/sec_tick_time_keeper.sv
// 24-hour BCD time-of-day kept from a synchronized 1 Hz square-wave tick,
// with a two-cycle validated load handshake.
// Optional macro TICK_WATCHDOG_EN builds a missing-tick watchdog driving
// o_tick_lost; without it o_tick_lost is tied low.
module sec_tick_time_keeper
  import time_keeper_pkg::*;
#(
  parameter int CLK_FREQ    = 12000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sec_tick,
  input  logic        i_run,
  input  logic        i_load_valid,
  input  logic [23:0] i_load_data,
  output logic        o_load_ready,
  output logic [23:0] o_time,
  output logic        o_sec_strobe,
  output logic        o_day_wrap,
  output logic        o_load_err,
  output logic        o_tick_lost
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   tick_prev_q;
  logic                   rise;

  state_e                 state_q, state_d;
  logic                   load_ready, in_check, accept;
  logic [TIME_W-1:0]      load_q;
  logic                   data_ok, commit, count_en;

  logic [7:0]             sec_val, min_val, hr_val;
  logic                   sec_carry, min_carry, hr_carry;
  logic                   sec_strobe_q, day_wrap_q, load_err_q;

  // Tick synchronizer chain plus edge register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q      <= '0;
      tick_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], i_sec_tick};
      tick_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~tick_prev_q;

  // Load FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Load FSM next state: CHECK always lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CHECK;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load FSM outputs decoded from the state register
  always_comb begin
    load_ready = (state_q == IDLE);
    in_check   = (state_q == CHECK);
  end

  assign accept = i_load_valid & load_ready;

  // Capture the requested time on accept
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       load_q <= '0;
    else if (accept) load_q <= i_load_data;
  end

  assign data_ok  = is_valid_time(load_q);
  assign commit   = in_check & data_ok;
  // Ticks landing in CHECK are dropped so a fresh load is never bumped.
  assign count_en = rise & i_run & load_ready;

  bcd_pair_counter #(.MODULUS(60)) u_sec (
    .clk_i        (i_clk),
    .rst_i        (i_rst),
    .inc_i        (count_en),
    .load_i       (commit),
    .load_value_i (load_q[S1_OFF +: 8]),
    .value_o      (sec_val),
    .carry_out_o  (sec_carry)
  );

  bcd_pair_counter #(.MODULUS(60)) u_min (
    .clk_i        (i_clk),
    .rst_i        (i_rst),
    .inc_i        (sec_carry),
    .load_i       (commit),
    .load_value_i (load_q[M1_OFF +: 8]),
    .value_o      (min_val),
    .carry_out_o  (min_carry)
  );

  bcd_pair_counter #(.MODULUS(24)) u_hr (
    .clk_i        (i_clk),
    .rst_i        (i_rst),
    .inc_i        (min_carry),
    .load_i       (commit),
    .load_value_i (load_q[H1_OFF +: 8]),
    .value_o      (hr_val),
    .carry_out_o  (hr_carry)
  );

  // One-cycle event pulses, registered alongside the time update
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sec_strobe_q <= 1'b0;
      day_wrap_q   <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      sec_strobe_q <= count_en;
      day_wrap_q   <= hr_carry;
      load_err_q   <= in_check & ~data_ok;
    end
  end

  assign o_time       = {hr_val, min_val, sec_val};
  assign o_load_ready = load_ready;
  assign o_sec_strobe = sec_strobe_q;
  assign o_day_wrap   = day_wrap_q;
  assign o_load_err   = load_err_q;

`ifdef TICK_WATCHDOG_EN
  // A quarter second of slack beyond the nominal one-second tick period
  localparam int TIMEOUT = CLK_FREQ + CLK_FREQ / 4;
  localparam int WD_W    = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            lost_q, lost_d;

  // Saturating cycles-since-rise count; lost flag sticks until next rise
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (rise | ~i_run)                     wd_cnt_d = '0;
    else if (wd_cnt_q != WD_W'(TIMEOUT))   wd_cnt_d = wd_cnt_q + 1'b1;
    lost_d = rise ? 1'b0 : (lost_q | (wd_cnt_d == WD_W'(TIMEOUT)));
  end

  // Watchdog registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wd_cnt_q <= '0;
      lost_q   <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      lost_q   <= lost_d;
    end
  end

  assign o_tick_lost = lost_q;
`else
  assign o_tick_lost = 1'b0;
`endif

endmodule

// File: tb/tb_sec_tick_time_keeper.sv
// Bench for sec_tick_time_keeper: seconds-of-day reference model checked
// every cycle, plus directed scenarios with literal expectations.
// Watchdog checks are built when TICK_WATCHDOG_EN is defined.
module tb_sec_tick_time_keeper;

  localparam int CLK_FREQ = 16;
  localparam int SYNC     = 2;
  localparam int TIMEOUT  = CLK_FREQ + CLK_FREQ / 4;

  logic        clk = 1'b0;
  logic        rst, tick, run, lv;
  logic [23:0] ld;
  logic        o_load_ready, o_sec_strobe, o_day_wrap, o_load_err, o_tick_lost;
  logic [23:0] o_time;

  always #5 clk = ~clk;

  sec_tick_time_keeper #(.CLK_FREQ(CLK_FREQ), .SYNC_STAGES(SYNC)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_sec_tick   (tick),
    .i_run        (run),
    .i_load_valid (lv),
    .i_load_data  (ld),
    .o_load_ready (o_load_ready),
    .o_time       (o_time),
    .o_sec_strobe (o_sec_strobe),
    .o_day_wrap   (o_day_wrap),
    .o_load_err   (o_load_err),
    .o_tick_lost  (o_tick_lost)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (time as seconds since midnight) ----
  function automatic int bcd2sec(input logic [23:0] t);
    int h, m, s;
    h = int'(t[23:20]) * 10 + int'(t[19:16]);
    m = int'(t[15:12]) * 10 + int'(t[11:8]);
    s = int'(t[7:4])   * 10 + int'(t[3:0]);
    return h * 3600 + m * 60 + s;
  endfunction

  function automatic logic [23:0] sec2bcd(input int x);
    int h, m, s;
    h = x / 3600;
    m = (x / 60) % 60;
    s = x % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic bit time_ok(input logic [23:0] t);
    int d[6];
    for (int i = 0; i < 6; i++) d[i] = int'(t[i*4 +: 4]);
    for (int i = 0; i < 6; i++) if (d[i] > 9) return 1'b0;
    return (d[1] <= 5) && (d[3] <= 5) && (d[5] * 10 + d[4] <= 23);
  endfunction

  int          m_secs;
  bit          m_busy, m_strobe, m_wrap, m_err, m_lost, m_rise;
  logic [23:0] m_pend;
  bit          hist[0:SYNC];   // hist[0] = tick level seen at the previous edge
  int          m_since;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_secs = 0; m_busy = 0; m_strobe = 0; m_wrap = 0; m_err = 0;
      m_lost = 0; m_since = 0; m_pend = '0;
      for (int i = 0; i <= SYNC; i++) hist[i] = 1'b0;
    end else begin
      // A low-to-high step seen SYNC edges ago takes effect now.
      m_rise   = hist[SYNC-1] && !hist[SYNC];
      m_strobe = 0; m_wrap = 0; m_err = 0;
      if (m_busy) begin
        if (time_ok(m_pend)) m_secs = bcd2sec(m_pend);
        else                 m_err = 1;
        m_busy = 0;
      end else begin
        if (m_rise && run) begin
          m_secs   = (m_secs + 1) % 86400;
          m_strobe = 1;
          m_wrap   = (m_secs == 0);
        end
        if (lv) begin
          m_busy = 1;
          m_pend = ld;
        end
      end
`ifdef TICK_WATCHDOG_EN
      if (m_rise || !run) m_since = 0;
      else if (m_since < TIMEOUT) m_since++;
      m_lost = m_rise ? 1'b0 : (m_lost || m_since >= TIMEOUT);
`endif
      for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = tick;
    end
  end

  bit cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("model_time",   o_time,       sec2bcd(m_secs));
      check("model_strobe", o_sec_strobe, m_strobe);
      check("model_wrap",   o_day_wrap,   m_wrap);
      check("model_err",    o_load_err,   m_err);
      check("model_ready",  o_load_ready, !m_busy);
      check("model_lost",   o_tick_lost,  m_lost);
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic do_load(input logic [23:0] d, output int errs);
    int guard = 0;
    errs = 0;
    while (!o_load_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("load_ready_timeout", 0, 1);
    lv = 1'b1;
    ld = d;
    @(negedge clk);
    lv = 1'b0;
    if (o_load_err) errs++;
    repeat (2) begin
      @(negedge clk);
      if (o_load_err) errs++;
    end
  endtask

  task automatic rise_and_watch(input int n, output int n_strobe, output int n_wrap,
                                output int first_at);
    n_strobe = 0; n_wrap = 0; first_at = -1;
    tick = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (o_sec_strobe) begin
        n_strobe++;
        if (first_at < 0) first_at = i;
      end
      if (o_day_wrap) n_wrap++;
    end
    tick = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e, ns, nw, fa;
    rst = 1'b1; tick = 1'b0; run = 1'b0; lv = 1'b0; ld = '0;
    @(negedge clk);
    check("reset_time",   o_time,       24'h000000);
    check("reset_ready",  o_load_ready, 1'b1);
    check("reset_strobe", o_sec_strobe, 1'b0);
    check("reset_err",    o_load_err,   1'b0);
    check("reset_lost",   o_tick_lost,  1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1;
    repeat (2) @(negedge clk);

    // Day wrap
    run = 1'b1;
    do_load(24'h235959, e);
    check("load_235959", o_time, 24'h235959);
    check("load_235959_err", e, 0);
    rise_and_watch(6, ns, nw, fa);
    check("wrap_time",     o_time, 24'h000000);
    check("wrap_strobes",  ns, 1);
    check("wrap_pulses",   nw, 1);
    check("wrap_latency",  fa, SYNC + 1);

    // Minute and hour carries
    do_load(24'h095959, e);
    rise_and_watch(5, ns, nw, fa);
    check("carry_hour", o_time, 24'h100000);
    check("carry_hour_nowrap", nw, 0);
    do_load(24'h000059, e);
    rise_and_watch(5, ns, nw, fa);
    check("carry_min", o_time, 24'h000100);

    // Invalid loads leave the time alone
    do_load(24'h240000, e);
    check("bad_hour_err", e, 1);
    check("bad_hour_time", o_time, 24'h000100);
    do_load(24'h006000, e);
    check("bad_min_err", e, 1);
    check("bad_min_time", o_time, 24'h000100);
    do_load(24'h00000A, e);
    check("bad_digit_err", e, 1);
    check("bad_digit_time", o_time, 24'h000100);

    // Rise landing in the CHECK cycle is dropped
    tick = 1'b1;
    @(negedge clk);
    lv = 1'b1; ld = 24'h010203;
    ns = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      lv = 1'b0;
      if (o_sec_strobe) ns++;
    end
    tick = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    check("collide_check_time",   o_time, 24'h010203);
    check("collide_check_strobe", ns, 0);

    // Rise in the accept cycle counts, then the load overwrites it
    tick = 1'b1;
    repeat (2) @(negedge clk);
    lv = 1'b1; ld = 24'h020304;
    ns = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      lv = 1'b0;
      if (o_sec_strobe) ns++;
    end
    tick = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    check("collide_accept_time",   o_time, 24'h020304);
    check("collide_accept_strobe", ns, 1);

    // Run gating
    run = 1'b0;
    repeat (3) begin
      rise_and_watch(5, ns, nw, fa);
      check("gated_strobe", ns, 0);
    end
    check("gated_time", o_time, 24'h020304);
    run = 1'b1;

`ifdef TICK_WATCHDOG_EN
    tick = 1'b1;
    repeat (3) @(negedge clk);
    check("wd_clear_on_rise", o_tick_lost, 1'b0);
    tick = 1'b0;
    repeat (19) @(negedge clk);
    check("wd_before_timeout", o_tick_lost, 1'b0);
    @(negedge clk);
    check("wd_set", o_tick_lost, 1'b1);
    repeat (5) @(negedge clk);
    check("wd_sticky", o_tick_lost, 1'b1);
    tick = 1'b1;
    repeat (2) @(negedge clk);
    check("wd_held_until_rise", o_tick_lost, 1'b1);
    @(negedge clk);
    check("wd_cleared", o_tick_lost, 1'b0);
    tick = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
`endif

    // Asynchronous reset mid-count
    do_load(24'h123456, e);
    check("pre_reset_time", o_time, 24'h123456);
    tick = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_time",  o_time,       24'h000000);
    check("async_reset_ready", o_load_ready, 1'b1);
    tick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_reset_time", o_time, 24'h000000);

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
